// File: rtl/program_loader.sv
// program_loader: receives a length-prefixed, checksummed byte stream,
// assembles big-endian 32-bit words and writes them into instruction memory.
// The processor core is released from reset only after a good checksum.
//
// Ports
//   clk          clock, rising edge
//   resetn       synchronous active-low reset
//   start        one-cycle pulse that begins a load (IDLE or ERROR only)
//   in_valid     in_data carries a byte
//   in_data[7:0] byte stream: N, N*4 payload bytes (MSB first), XOR checksum
//   in_ready     a byte is accepted this cycle when in_valid is also high
//   imem_we      instruction-memory write strobe (one cycle per word)
//   imem_addr    word address, valid while imem_we=1
//   imem_wdata   assembled word, valid while imem_we=1
//   core_resetn  core reset, high = released (RUN only)
//   done         load completed with a matching checksum
//   error        load failed (bad length or checksum)
//   word_count   words written in the current load (0..16)
//
// state   | meaning
// IDLE    | waiting for start after reset
// LEN     | accepting the length byte N
// DATA    | accepting payload bytes of the current word
// WRITE   | one-cycle instruction-memory write of the assembled word
// CSUM    | accepting and comparing the checksum byte
// RUN     | load good, core released; held until resetn
// ERROR   | load failed; start retries
module program_loader (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        imem_we,
   output logic [3:0]  imem_addr,
   output logic [31:0] imem_wdata,
   output logic        core_resetn,
   output logic        done,
   output logic        error,
   output logic [4:0]  word_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_RUN, S_ERROR
   } state_t;

   state_t      state, state_nxt;
   logic [4:0]  len_q, len_nxt;
   logic [3:0]  idx_q, idx_nxt;
   logic [1:0]  bcnt_q, bcnt_nxt;
   logic [7:0]  acc_q, acc_nxt;
   logic [31:0] word_q, word_nxt;
   logic [4:0]  wcnt_q, wcnt_nxt;
   logic        hs;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state  <= S_IDLE;
         len_q  <= '0;
         idx_q  <= '0;
         bcnt_q <= '0;
         acc_q  <= '0;
         word_q <= '0;
         wcnt_q <= '0;
      end else begin
         state  <= state_nxt;
         len_q  <= len_nxt;
         idx_q  <= idx_nxt;
         bcnt_q <= bcnt_nxt;
         acc_q  <= acc_nxt;
         word_q <= word_nxt;
         wcnt_q <= wcnt_nxt;
      end
   end

   // All outputs decode from registered state only; in_ready never sees in_valid.
   assign in_ready    = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
   assign imem_we     = (state == S_WRITE);
   assign imem_addr   = idx_q;
   assign imem_wdata  = word_q;
   assign core_resetn = (state == S_RUN);
   assign done        = (state == S_RUN);
   assign error       = (state == S_ERROR);
   assign word_count  = wcnt_q;
   assign hs          = in_valid && in_ready;

   always_comb begin
      state_nxt = state;
      len_nxt   = len_q;
      idx_nxt   = idx_q;
      bcnt_nxt  = bcnt_q;
      acc_nxt   = acc_q;
      word_nxt  = word_q;
      wcnt_nxt  = wcnt_q;

      case (state)
         S_IDLE, S_ERROR: begin
            if (start) begin
               state_nxt = S_LEN;
               len_nxt   = '0;
               idx_nxt   = '0;
               bcnt_nxt  = '0;
               acc_nxt   = '0;
               word_nxt  = '0;
               wcnt_nxt  = '0;
            end
         end
         S_LEN: begin
            if (hs) begin
               if ((in_data == 8'd0) || (in_data > 8'd16)) begin
                  state_nxt = S_ERROR;
               end else begin
                  len_nxt   = in_data[4:0];
                  state_nxt = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (hs) begin
               word_nxt = {word_q[23:0], in_data};
               acc_nxt  = acc_q ^ in_data;
               bcnt_nxt = bcnt_q + 2'd1;
               if (bcnt_q == 2'd3) begin
                  state_nxt = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            wcnt_nxt = wcnt_q + 5'd1;
            idx_nxt  = idx_q + 4'd1;
            // len_q is at least 1 here, so len_q-1 fits in the index range.
            if ({1'b0, idx_q} == (len_q - 5'd1)) begin
               state_nxt = S_CSUM;
            end else begin
               state_nxt = S_DATA;
            end
         end
         S_CSUM: begin
            if (hs) begin
               state_nxt = (in_data == acc_q) ? S_RUN : S_ERROR;
            end
         end
         S_RUN: begin
            state_nxt = S_RUN;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

   logic        clk;
   logic        resetn;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        imem_we;
   logic [3:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        core_resetn;
   logic        done;
   logic        error;
   logic [4:0]  word_count;

   int n_assert = 0;
   int n_fail   = 0;
   int we_count = 0;
   int we_snap;

   logic [35:0] exp_q[$];
   logic [31:0] prog[16];

   program_loader dut (
      .clk         (clk),
      .resetn      (resetn),
      .start       (start),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .imem_we     (imem_we),
      .imem_addr   (imem_addr),
      .imem_wdata  (imem_wdata),
      .core_resetn (core_resetn),
      .done        (done),
      .error       (error),
      .word_count  (word_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every write strobe pops one expected {addr, data}.
   always @(negedge clk) begin
      logic [35:0] e;
      if (imem_we === 1'b1) begin
         we_count++;
         if (exp_q.size() == 0) begin
            check("unexpected_write_addr", {28'd0, imem_addr}, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("write_addr", {28'd0, imem_addr}, {28'd0, e[35:32]});
            check("write_data", imem_wdata, e[31:0]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
         in_data = 8'($urandom);
         tick();
      end
      in_valid = 1'b1;
      in_data  = b;
      t = 0;
      while (in_ready !== 1'b1 && t < 50) begin
         tick();
         t++;
      end
      if (t >= 50) check("handshake_timeout", t, 0);
      tick();
   endtask

   function automatic int pick_gap(input int max_gap);
      return (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0));
   endfunction

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
   endtask

   task automatic load(input int n, input int max_gap, input bit bad);
      logic [7:0] acc;
      logic [7:0] b;
      acc = 8'h00;
      send_byte(8'(n), pick_gap(max_gap));
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({4'(i), prog[i]});
         for (int k = 3; k >= 0; k--) begin
            b   = prog[i][8*k +: 8];
            acc = acc ^ b;
            send_byte(b, pick_gap(max_gap));
         end
      end
      send_byte(bad ? 8'h00 : acc, pick_gap(max_gap));
      in_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
      check({tag, "_imem_we"}, {31'd0, imem_we}, 32'd0);
      check({tag, "_core_resetn"}, {31'd0, core_resetn}, 32'd0);
      check({tag, "_done"}, {31'd0, done}, 32'd0);
      check({tag, "_error"}, {31'd0, error}, 32'd0);
      check({tag, "_word_count"}, {27'd0, word_count}, 32'd0);
   endtask

   initial begin
      resetn   = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      prog[0]  = 32'h9000_000A;
      prog[1]  = 32'h9001_0004;
      for (int i = 2; i < 16; i++) prog[i] = 32'h0;
      repeat (3) tick();
      check_reset_outputs("reset");
      resetn = 1'b1;
      tick();
      check_reset_outputs("idle");

      // Nominal load
      pulse_start();
      check("len_in_ready", {31'd0, in_ready}, 32'd1);
      we_snap = we_count;
      load(2, 0, 1'b0);
      check("nom_done", {31'd0, done}, 32'd1);
      check("nom_core_resetn", {31'd0, core_resetn}, 32'd1);
      check("nom_error", {31'd0, error}, 32'd0);
      check("nom_word_count", {27'd0, word_count}, 32'd2);
      check("nom_writes", we_count - we_snap, 32'd2);
      check("nom_q_empty", exp_q.size(), 32'd0);
      pulse_start();
      tick();
      check("run_ignores_start_done", {31'd0, done}, 32'd1);
      check("run_ignores_start_ready", {31'd0, in_ready}, 32'd0);

      // Bad checksum, then recovery from ERROR through bad lengths
      do_reset();
      check_reset_outputs("after_run_reset");
      pulse_start();
      load(2, 0, 1'b1);
      check("badcs_error", {31'd0, error}, 32'd1);
      check("badcs_core_resetn", {31'd0, core_resetn}, 32'd0);
      check("badcs_done", {31'd0, done}, 32'd0);
      check("badcs_word_count", {27'd0, word_count}, 32'd2);
      check("badcs_q_empty", exp_q.size(), 32'd0);
      pulse_start();
      check("retry_error_clear", {31'd0, error}, 32'd0);
      check("retry_word_count", {27'd0, word_count}, 32'd0);
      check("retry_in_ready", {31'd0, in_ready}, 32'd1);

      we_snap = we_count;
      send_byte(8'h00, 0);
      in_valid = 1'b0;
      check("len0_error", {31'd0, error}, 32'd1);
      pulse_start();
      send_byte(8'h11, 0);
      in_valid = 1'b0;
      check("len17_error", {31'd0, error}, 32'd1);
      check("len17_core_resetn", {31'd0, core_resetn}, 32'd0);
      tick();
      check("badlen_no_writes", we_count - we_snap, 32'd0);
      pulse_start();
      load(2, 0, 1'b0);
      check("after_badlen_done", {31'd0, done}, 32'd1);
      check("after_badlen_word_count", {27'd0, word_count}, 32'd2);

      // Flow control with random gaps; valid stays high across WRITE
      do_reset();
      pulse_start();
      we_snap = we_count;
      load(2, 3, 1'b0);
      check("flow_done", {31'd0, done}, 32'd1);
      check("flow_word_count", {27'd0, word_count}, 32'd2);
      check("flow_writes", we_count - we_snap, 32'd2);
      check("flow_q_empty", exp_q.size(), 32'd0);

      // Reset after 6 payload bytes
      do_reset();
      pulse_start();
      we_snap = we_count;
      exp_q.push_back({4'd0, prog[0]});
      send_byte(8'h02, 0);
      send_byte(8'h90, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h0A, 0);
      send_byte(8'h90, 0);
      send_byte(8'h01, 0);
      in_valid = 1'b0;
      resetn   = 1'b0;
      tick();
      check_reset_outputs("midload_reset");
      resetn = 1'b1;
      repeat (3) tick();
      check("midload_writes", we_count - we_snap, 32'd1);
      check("midload_q_empty", exp_q.size(), 32'd0);
      check_reset_outputs("midload_idle");
      pulse_start();
      load(2, 0, 1'b0);
      check("midload_reload_done", {31'd0, done}, 32'd1);
      check("midload_reload_word_count", {27'd0, word_count}, 32'd2);

      // Full 16-word program
      for (int i = 0; i < 16; i++) prog[i] = (32'h0123_4567 * (i + 1)) ^ 32'hA5A5_0000;
      do_reset();
      pulse_start();
      we_snap = we_count;
      load(16, 1, 1'b0);
      check("full_done", {31'd0, done}, 32'd1);
      check("full_core_resetn", {31'd0, core_resetn}, 32'd1);
      check("full_word_count", {27'd0, word_count}, 32'd16);
      check("full_writes", we_count - we_snap, 32'd16);
      check("full_q_empty", exp_q.size(), 32'd0);

      repeat (2) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL use clock clk and reset resetn; resetn is synchronous and active-low.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: clock, rising edge.
- resetn, in, 1: synchronous active-low reset.
- start, in, 1: single-cycle pulse; begins a load.
- in_valid, in, 1: in_data carries a byte.
- in_data, in, 8: byte stream.
- in_ready, out, 1: block accepts a byte this cycle.
- imem_we, out, 1: instruction-memory write strobe.
- imem_addr, out, 4: instruction-memory word address.
- imem_wdata, out, 32: instruction word.
- core_resetn, out, 1: active-low reset to the processor core; high = core released.
- done, out, 1: load completed successfully.
- error, out, 1: load failed.
- word_count, out, 5: words written in the current load (0..16).

Function
REQ-003 A byte SHALL be consumed only on a handshake cycle (in_valid=1 and in_ready=1); a byte offered while in_ready=0 SHALL NOT be consumed.
REQ-004 Stream format SHALL be: one length byte N, then N×4 payload bytes (each word big-endian, MSB first), then one checksum byte equal to the XOR of all payload bytes.
REQ-005 States SHALL be IDLE, LEN, DATA, WRITE, CSUM, RUN, ERROR.
REQ-006 IDLE: in_ready=0; a start pulse SHALL move to LEN and clear word index, byte count, checksum accumulator and word_count.
REQ-007 LEN: in_ready=1; on handshake, N SHALL be captured; 1≤N≤16 → DATA; N=0 or N>16 → ERROR.
REQ-008 DATA: in_ready=1; each handshake SHALL shift the byte in (word = {word[23:0], byte}) and XOR it into the accumulator; the 4th byte SHALL move to WRITE.
REQ-009 WRITE: in_ready=0; imem_we=1 for exactly one cycle with imem_addr = word index and imem_wdata = assembled word; word_count SHALL increment in the same cycle.
REQ-010 WRITE exit: if word index = N-1 → CSUM, else → DATA; the index increments modulo 16.
REQ-011 Write latency: imem_we SHALL assert in the cycle immediately after the 4th byte handshake of a word.
REQ-012 CSUM: in_ready=1; on handshake, byte = accumulator → RUN, otherwise → ERROR.
REQ-013 RUN: core_resetn=1 and done=1 from the cycle after the checksum handshake; the block SHALL hold RUN until resetn; start is ignored.
REQ-014 ERROR: error=1 and core_resetn=0; a start pulse SHALL re-enter LEN with all counters and the accumulator cleared, and error SHALL deassert.
REQ-015 start SHALL be ignored in LEN, DATA, WRITE, CSUM and RUN.
REQ-016 Words already written before an ERROR SHALL NOT be retracted.
REQ-017 imem_addr and imem_wdata are don't-care when imem_we=0.
REQ-018 in_ready SHALL be a function of registered state only (no combinational path from in_valid).

Reset
REQ-019 While resetn=0 at a rising edge, the block SHALL enter IDLE and drive in_ready=0, imem_we=0, core_resetn=0, done=0, error=0, word_count=0, with all internal counters and the accumulator cleared.
REQ-020 Reset asserted mid-load SHALL abort the load immediately, with no further imem_we pulses and no partial word written.

Verification
REQ-021 Nominal load: start, then bytes 02, 90 00 00 0A, 90 01 00 04, 0F.
- Required: writes addr0=0x9000000A and addr1=0x90010004, one imem_we cycle each.
- Required: word_count=2; core_resetn=1 and done=1 the cycle after the 0F handshake.
REQ-022 Bad checksum: same stream with final byte 00.
- Required: both writes occur, then error=1 with core_resetn=0 and done=0.
REQ-023 Length bounds: length byte 00, and separately 11 (hex).
- Required: ERROR the cycle after the length handshake; no imem_we; a subsequent start followed by a valid stream reaches RUN.
REQ-024 Flow control: random in_valid gaps, and in_valid held high during WRITE.
- Required: identical memory contents to REQ-021; no byte is consumed while in_ready=0.
REQ-025 Reset mid-load: resetn low for one cycle after 6 payload bytes of REQ-021.
- Required: only the addr0 write occurred; all outputs return to reset values; a fresh start and full stream completes normally.
REQ-026 Full program: N=16 with 64 payload bytes and correct checksum.
- Required: addresses 0..15 are written in order; word_count=16; RUN is reached.
